dmem_bank: RTL and testbench

Parametrised successor to the CPU data memory: synchronous-read word memory with configurable width and depth. Adds per-byte write enables, write-forwarding of the merged word, out-of-range address detection and a post-reset zero-initialisation sequencer. Sits in the CPU MEM stage; keeps the existing clear/hold pipeline controls and adds a ready flag for the hazard unit.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_init_seq.sv | 45 ++++
 rtl/dmem_bank.sv | 78 +++++++
 tb/tb_dmem_bank.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types, default sizing and the byte-merge helper for the data memory bank.
package dmem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_DEPTH  = 128;

  // Widest word be_merge handles; callers zero-extend and truncate around it.
  localparam int unsigned MAX_W  = 512;
  localparam int unsigned MAX_BE = MAX_W / 8;

  // Byte i of the result comes from new_w where be[i]=1, else from old_w.
  function automatic logic [MAX_W-1:0] be_merge(input logic [MAX_W-1:0]  old_w,
                                                input logic [MAX_W-1:0]  new_w,
                                                input logic [MAX_BE-1:0] be);
    logic [MAX_W-1:0] r;
    r = old_w;
    for (int unsigned i = 0; i < MAX_BE; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_init_seq.sv
// Post-reset zero-fill sequencer: walks every word index once, then enters RUN.
module dmem_init_seq
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH      = DMEM_DEPTH,
  parameter bit          INIT_CLEAR = 1'b1,
  localparam int unsigned IDX_W     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  output logic             ready,
  output logic             init_we,
  output logic [IDX_W-1:0] init_idx
);

  state_t           state;
  logic [IDX_W-1:0] cnt;

  // INIT/RUN FSM with fill counter; ready is registered and rises on the last fill write.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= INIT_CLEAR ? INIT : RUN;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == IDX_W'(DEPTH - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: ready <= 1'b1;
      endcase
    end
  end

  // Fill write strobe and index follow the state directly.
  always_comb begin
    init_we  = (state == INIT);
    init_idx = cnt;
  end

endmodule

// File: rtl/dmem_bank.sv
// Synchronous-read data memory with byte enables, write-through, range check and zero-fill.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W     = DMEM_DATA_W,
  parameter int unsigned DEPTH      = DMEM_DEPTH,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [31:0]         addr,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   data,
  input  logic                clear,
  input  logic                hold,
  output logic [DATA_W-1:0]   q,
  output logic                ready,
  output logic                err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              inr;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] merged;
  logic              init_we;
  logic [IDX_W-1:0]  init_idx;

  dmem_init_seq #(
    .DEPTH      (DEPTH),
    .INIT_CLEAR (INIT_CLEAR)
  ) u_init_seq (
    .clk      (clk),
    .resetn   (resetn),
    .ready    (ready),
    .init_we  (init_we),
    .init_idx (init_idx)
  );

  // Range check on the full address, index decode and byte-merged write word.
  always_comb begin
    inr     = (addr < 32'(DEPTH));
    idx     = addr[IDX_W-1:0];
    rd_word = mem[idx];
    merged  = DATA_W'(be_merge(MAX_W'(rd_word), MAX_W'(data), MAX_BE'(be)));
  end

  // Storage write port: zero-fill while sequencing, byte-merged writes once ready.
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (init_we) begin
        mem[init_idx] <= '0;
      end else if (ready && we && inr) begin
        mem[idx] <= merged;
      end
    end
  end

  // Read register and error flag; the merged word gives write-through on the same cycle.
  always_ff @(posedge clk) begin
    if (!resetn || !ready) begin
      q   <= '0;
      err <= 1'b0;
    end else begin
      err <= !inr && (we || !(clear || hold));
      if (clear)     q <= '0;
      else if (hold) q <= q;
      else if (!inr) q <= '0;
      else if (we)   q <= merged;
      else           q <= rd_word;
    end
  end

endmodule

// File: tb/tb_dmem_bank.sv
// Scoreboard bench for dmem_bank: default instance (32x128, zero-fill) and a
// 64x100 instance without zero-fill, both checked against a behavioural model.
module tb_dmem_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: defaults
  logic        resetn0 = 1'b0;
  logic [31:0] addr0   = '0;
  logic        we0     = 1'b0;
  logic [3:0]  be0     = '0;
  logic [31:0] data0   = '0;
  logic        clear0  = 1'b0;
  logic        hold0   = 1'b0;
  logic [31:0] q0;
  logic        ready0, err0;

  // Instance 1: 64-bit, 100 words, no zero-fill
  logic        resetn1 = 1'b0;
  logic [31:0] addr1   = '0;
  logic        we1     = 1'b0;
  logic [7:0]  be1     = '0;
  logic [63:0] data1   = '0;
  logic        clear1  = 1'b0;
  logic        hold1   = 1'b0;
  logic [63:0] q1;
  logic        ready1, err1;

  dmem_bank u_dut0 (
    .clk(clk), .resetn(resetn0), .addr(addr0), .we(we0), .be(be0), .data(data0),
    .clear(clear0), .hold(hold0), .q(q0), .ready(ready0), .err(err0)
  );

  dmem_bank #(.DATA_W(64), .DEPTH(100), .INIT_CLEAR(1'b0)) u_dut1 (
    .clk(clk), .resetn(resetn1), .addr(addr1), .we(we1), .be(be1), .data(data1),
    .clear(clear1), .hold(hold1), .q(q1), .ready(ready1), .err(err1)
  );

  typedef struct {
    string       tag;
    logic [63:0] q;
    logic        err;
    logic        rdy;
    bit          chk_q;
  } exp_t;

  exp_t sb [2][$];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int unsigned depth  [2] = '{128, 100};
  int unsigned nbytes [2] = '{4, 8};
  int unsigned lat    [2] = '{128, 1};   // cycles from reset release until ready
  int unsigned k      [2] = '{0, 0};     // edges seen with reset released
  logic [63:0] rmem   [2][128];
  bit          known  [2][128];
  logic [63:0] refq   [2];
  bit          refq_k [2];

  task automatic cmp(input string tag, input string what, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s got=%h exp=%h", tag, what, act, exp);
    end
  endtask

  // Issue one cycle of stimulus and push the expected post-edge response.
  task automatic drive(input int d, input string tag, input logic rn, input logic [31:0] a,
                       input logic w, input logic [7:0] b, input logic [63:0] dat,
                       input logic c, input logic h);
    exp_t        e;
    logic [63:0] dm, merged;
    logic [63:0] old;
    bit          inr, acc, full;
    int unsigned ix;
    @(negedge clk);
    if (d == 0) begin
      resetn0 = rn; addr0 = a; we0 = w; be0 = b[3:0]; data0 = dat[31:0];
      clear0 = c; hold0 = h;
    end else begin
      resetn1 = rn; addr1 = a; we1 = w; be1 = b; data1 = dat;
      clear1 = c; hold1 = h;
    end
    e.tag = tag; e.chk_q = 1'b1; e.q = '0; e.err = 1'b0; e.rdy = 1'b0;
    if (!rn) begin
      k[d] = 0;
      refq[d] = '0; refq_k[d] = 1'b1;
      if (d == 0) for (int i = 0; i < 128; i++) begin rmem[0][i] = '0; known[0][i] = 1'b1; end
    end else begin
      k[d]++;
      acc   = (k[d] > lat[d]);
      e.rdy = (k[d] >= lat[d]);
      if (!acc) begin
        refq[d] = '0; refq_k[d] = 1'b1;
      end else begin
        inr  = (a < depth[d]);
        ix   = a % 128;
        dm   = (d == 0) ? (dat & 64'hFFFF_FFFF) : dat;
        old  = inr ? rmem[d][ix] : '0;
        full = 1'b1;
        merged = old;
        for (int unsigned i = 0; i < nbytes[d]; i++) begin
          if (b[i]) merged[8*i +: 8] = dm[8*i +: 8];
          else full = 1'b0;
        end
        e.err = !inr && (w || !(c || h));
        if (c)        begin e.q = '0; e.chk_q = 1'b1; end
        else if (h)   begin e.q = refq[d]; e.chk_q = refq_k[d]; end
        else if (!inr) begin e.q = '0; e.chk_q = 1'b1; end
        else if (w)   begin e.q = merged; e.chk_q = known[d][ix] || full; end
        else          begin e.q = old; e.chk_q = known[d][ix]; end
        refq[d] = e.q; refq_k[d] = e.chk_q;
        if (w && inr) begin
          rmem[d][ix]  = merged;
          known[d][ix] = known[d][ix] || full;
        end
      end
    end
    sb[d].push_back(e);
  endtask

  // Monitor: after every edge, compare whatever response each scoreboard expects.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb[0].size() != 0) begin
      e = sb[0].pop_front();
      cmp(e.tag, "ready0", {63'd0, ready0}, {63'd0, e.rdy});
      cmp(e.tag, "err0", {63'd0, err0}, {63'd0, e.err});
      if (e.chk_q) cmp(e.tag, "q0", {32'd0, q0}, e.q);
    end
    if (sb[1].size() != 0) begin
      e = sb[1].pop_front();
      cmp(e.tag, "ready1", {63'd0, ready1}, {63'd0, e.rdy});
      cmp(e.tag, "err1", {63'd0, err1}, {63'd0, e.err});
      if (e.chk_q) cmp(e.tag, "q1", q1, e.q);
    end
  end

  task automatic junk(input int d, input string tag, input int n);
    for (int i = 0; i < n; i++)
      drive(d, tag, 1'b1, $urandom_range(0, 140), 1'($urandom), 8'($urandom),
            {$urandom, $urandom}, 1'($urandom), 1'($urandom));
  endtask

  task automatic rnd(input int d, input string tag, input int n, input int unsigned amax);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, amax);
      drive(d, tag, 1'b1, a, 1'($urandom), 8'($urandom), {$urandom, $urandom},
            $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin known[1][i] = 1'b0; rmem[1][i] = '0; end

    // Instance 0: reset, partial fill, reset mid-fill, full fill with ignored traffic
    drive(0, "rst", 1'b0, 0, 0, 0, 0, 0, 0);
    drive(0, "rst", 1'b0, 0, 0, 0, 0, 0, 0);
    junk(0, "init_a", 40);
    drive(0, "rst_mid", 1'b0, 5, 1, 8'hF, 64'hFFFF_FFFF, 0, 0);
    drive(0, "rst_mid", 1'b0, 5, 1, 8'hF, 64'hFFFF_FFFF, 0, 0);
    junk(0, "fill", 128);
    for (int unsigned i = 0; i < 128; i++) drive(0, "zero", 1'b1, i, 0, 0, 0, 0, 0);

    // Directed RUN cases
    drive(0, "rd5",  1'b1, 5, 0, 0, 0, 0, 0);
    drive(0, "be1",  1'b1, 3, 1, 8'hF, 64'h1122_3344, 0, 0);
    drive(0, "be2",  1'b1, 3, 1, 8'h5, 64'hAABB_CCDD, 0, 0);
    drive(0, "be3",  1'b1, 3, 0, 0, 0, 0, 0);
    drive(0, "clrw", 1'b1, 7, 1, 8'hF, 64'hDEAD_BEEF, 1, 0);
    drive(0, "clrr", 1'b1, 7, 0, 0, 0, 0, 0);
    drive(0, "pre",  1'b1, 3, 0, 0, 0, 0, 0);
    drive(0, "hold", 1'b1, 7, 0, 0, 0, 0, 1);
    drive(0, "oorw", 1'b1, 128, 1, 8'hF, 64'hFFFF_FFFF, 0, 0);
    drive(0, "oor0", 1'b1, 0, 0, 0, 0, 0, 0);
    drive(0, "oorr", 1'b1, 32'h8000_0000, 0, 0, 0, 0, 0);
    drive(0, "oorz", 1'b1, 0, 0, 0, 0, 0, 0);
    drive(0, "oorc", 1'b1, 200, 1, 8'hF, 64'h1234_5678, 1, 0);
    drive(0, "oorh", 1'b1, 300, 0, 0, 0, 0, 1);
    rnd(0, "rand0", 400, 135);
    drive(0, "idle0", 1'b1, 0, 0, 0, 0, 0, 0);

    // Instance 1: no fill, 64-bit words, 100 entries
    drive(1, "rst1", 1'b0, 0, 0, 0, 0, 0, 0);
    drive(1, "rst1", 1'b0, 0, 0, 0, 0, 0, 0);
    drive(1, "rdy1", 1'b1, 99, 1, 8'hFF, 64'h5555_5555_5555_5555, 0, 0);
    drive(1, "w99",  1'b1, 99, 1, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 0);
    drive(1, "r99",  1'b1, 99, 0, 0, 0, 0, 0);
    drive(1, "p99",  1'b1, 99, 1, 8'h0F, 64'hFFEE_DDCC_BBAA_9988, 0, 0);
    drive(1, "r99b", 1'b1, 99, 0, 0, 0, 0, 0);
    drive(1, "o100", 1'b1, 100, 1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    drive(1, "omax", 1'b1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    drive(1, "r99c", 1'b1, 99, 0, 0, 0, 0, 0);
    rnd(1, "rand1", 300, 103);
    drive(1, "idle1", 1'b1, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb[0].size() != 0 || sb[1].size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb[0].size() + sb[1].size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
